// File: rtl/lane_row.sv
// lane_row: one row of identical moving objects sharing a Y coordinate, with spawn init, wrap stepping
// and registered frog collision. Define ROW_CARRY_EN to drive carry_step/carry_dir for riding frogs.
//
// state | meaning
// INIT  | writing spawn positions, one slot per frame; busy high
// RUN   | objects step 1 px every `speed` frames
// PAUSE | positions and frame divider frozen
module lane_row #(
    parameter int MAX_OBJS = 8,
    parameter int OBJ_W    = 40,
    parameter int SCREEN_W = 640,
    parameter int X_W      = 11,
    localparam int CNT_W   = $clog2(MAX_OBJS + 1),
    localparam int IDX_W   = (MAX_OBJS > 1) ? $clog2(MAX_OBJS) : 1
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    cfg_load,
    input  logic                    run_en,
    input  logic [CNT_W-1:0]        num_objs,
    input  logic [7:0]              gap_size,
    input  logic [5:0]              speed,
    input  logic                    direction,
    input  logic [X_W-1:0]          row_y,
    input  logic [X_W-1:0]          frog_x,
    input  logic [X_W-1:0]          frog_y,
    output logic [MAX_OBJS*X_W-1:0] obj_x,
    output logic [X_W-1:0]          obj_y,
    output logic [MAX_OBJS-1:0]     obj_valid,
    output logic                    collision,
    output logic [IDX_W-1:0]        hit_idx,
    output logic                    busy,
    output logic                    carry_step,
    output logic                    carry_dir
);

    localparam int WRAP = SCREEN_W + OBJ_W;
    localparam logic [X_W-1:0] WRAP_M1 = X_W'(WRAP - 1);
    localparam logic [X_W:0]   WRAP_X  = (X_W + 1)'(WRAP);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    num_l;
    logic [7:0]          gap_l;
    logic [5:0]          speed_l;
    logic                dir_l;
    logic [X_W-1:0]      row_l;
    logic [X_W-1:0]      pos [MAX_OBJS];
    logic [X_W-1:0]      last_x;
    logic [IDX_W-1:0]    init_idx;
    logic [5:0]          div_cnt;

    logic [CNT_W-1:0]    num_clamp;
    logic [MAX_OBJS-1:0] mask_l;
    logic [MAX_OBJS-1:0] mask_in;
    logic [X_W:0]        init_sum;
    logic [X_W-1:0]      init_x;
    logic                step_now;
    logic [MAX_OBJS-1:0] hit;
    logic [IDX_W-1:0]    hit_sel;

    assign num_clamp = (num_objs > CNT_W'(MAX_OBJS)) ? CNT_W'(MAX_OBJS) : num_objs;
    assign busy      = (state == ST_INIT);
    assign step_now  = (state == ST_RUN) && (speed_l != 6'd0) && (div_cnt == speed_l - 6'd1);

    always_comb begin
        mask_l  = '0;
        mask_in = '0;
        for (int i = 0; i < MAX_OBJS; i++) begin
            mask_l[i]  = CNT_W'(i) < num_l;
            mask_in[i] = CNT_W'(i) < num_clamp;
        end
    end

    // gap <= 255 keeps the sum below 2*WRAP, so one subtract suffices
    always_comb begin
        init_sum = {1'b0, last_x} + (X_W + 1)'(gap_l) + (X_W + 1)'(OBJ_W);
        if (init_idx == '0)
            init_x = '0;
        else if (init_sum >= WRAP_X)
            init_x = X_W'(init_sum - WRAP_X);
        else
            init_x = init_sum[X_W-1:0];
    end

    // Compare one bit wider so frog_x + OBJ_W cannot overflow
    always_comb begin
        hit     = '0;
        hit_sel = '0;
        for (int i = 0; i < MAX_OBJS; i++) begin
            hit[i] = obj_valid[i] && (frog_y == obj_y)
                     && ({1'b0, pos[i]} <= ({1'b0, frog_x} + (X_W + 1)'(OBJ_W)))
                     && (frog_x < pos[i]);
        end
        for (int i = MAX_OBJS - 1; i >= 0; i--) begin
            if (hit[i]) hit_sel = IDX_W'(i);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            num_l     <= num_clamp;
            gap_l     <= gap_size;
            speed_l   <= speed;
            dir_l     <= direction;
            row_l     <= row_y;
            state     <= ST_INIT;
            init_idx  <= '0;
            last_x    <= '0;
            div_cnt   <= '0;
            obj_y     <= '0;
            obj_valid <= '0;
            collision <= 1'b0;
            hit_idx   <= '0;
            for (int i = 0; i < MAX_OBJS; i++) pos[i] <= '0;
        end else if (cfg_load) begin
            num_l     <= num_clamp;
            gap_l     <= gap_size;
            speed_l   <= speed;
            dir_l     <= direction;
            row_l     <= row_y;
            state     <= ST_INIT;
            init_idx  <= '0;
            div_cnt   <= '0;
            obj_y     <= row_y;
            obj_valid <= mask_in;
            collision <= 1'b0;
            hit_idx   <= '0;
        end else begin
            collision <= (state != ST_INIT) && (|hit);
            hit_idx   <= (state != ST_INIT) ? hit_sel : '0;
            case (state)
                ST_INIT: begin
                    pos[init_idx] <= init_x;
                    last_x        <= init_x;
                    obj_valid     <= mask_l;
                    obj_y         <= row_l;
                    if (init_idx == IDX_W'(MAX_OBJS - 1)) begin
                        init_idx <= '0;
                        state    <= run_en ? ST_RUN : ST_PAUSE;
                    end else begin
                        init_idx <= init_idx + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!run_en) state <= ST_PAUSE;
                    if (speed_l == 6'd0) begin
                        div_cnt <= '0;
                    end else if (step_now) begin
                        div_cnt <= '0;
                        for (int i = 0; i < MAX_OBJS; i++) begin
                            if (dir_l)
                                pos[i] <= (pos[i] == WRAP_M1) ? '0 : pos[i] + X_W'(1);
                            else
                                pos[i] <= (pos[i] == '0) ? WRAP_M1 : pos[i] - X_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + 6'd1;
                    end
                end
                ST_PAUSE: begin
                    if (run_en) state <= ST_RUN;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_OBJS; g++) begin : g_pack
        assign obj_x[g*X_W +: X_W] = pos[g];
    end

`ifdef ROW_CARRY_EN
    logic carry_r;

    // Pulse only on edges that actually move the row while the frog sits on it
    always_ff @(posedge frame_clk) begin
        if (!Reset || cfg_load)
            carry_r <= 1'b0;
        else
            carry_r <= step_now && collision;
    end

    assign carry_step = carry_r;
    assign carry_dir  = dir_l;
`else
    assign carry_step = 1'b0;
    assign carry_dir  = 1'b0;
`endif

endmodule

// File: tb/tb_lane_row.sv
// Self-checking bench for lane_row: positions modelled in closed form (spawn offset +/- step count mod WRAP).
module tb_lane_row;
    localparam int NOBJ = 8;
    localparam int OW   = 40;
    localparam int WRAP = 680;

    logic        frame_clk;
    logic        Reset;
    logic        cfg_load;
    logic        run_en;
    logic [3:0]  num_objs;
    logic [7:0]  gap_size;
    logic [5:0]  speed;
    logic        direction;
    logic [10:0] row_y;
    logic [10:0] frog_x;
    logic [10:0] frog_y;
    logic [87:0] obj_x;
    logic [10:0] obj_y;
    logic [7:0]  obj_valid;
    logic        collision;
    logic [2:0]  hit_idx;
    logic        busy;
    logic        carry_step;
    logic        carry_dir;

    lane_row dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .cfg_load  (cfg_load),
        .run_en    (run_en),
        .num_objs  (num_objs),
        .gap_size  (gap_size),
        .speed     (speed),
        .direction (direction),
        .row_y     (row_y),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .obj_valid (obj_valid),
        .collision (collision),
        .hit_idx   (hit_idx),
        .busy      (busy),
        .carry_step(carry_step),
        .carry_dir (carry_dir)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot_x(input int i);
        return int'(obj_x[i*11 +: 11]);
    endfunction

`ifdef ROW_CARRY_EN
    localparam bit CARRY_ON = 1'b1;
`else
    localparam bit CARRY_ON = 1'b0;
`endif

    // model: phase 0=init 1=run 2=pause
    bit       m_known = 1'b0;
    int       m_phase, m_icnt, m_frames;
    int       m_num, m_gap, m_speed, m_dir, m_rowy;
    int       m_x [NOBJ];
    int       m_valid, m_objy, m_coll, m_hit, m_carry;

    function automatic int clamp_mask(input int n);
        int c;
        c = (n > NOBJ) ? NOBJ : n;
        return (1 << c) - 1;
    endfunction

    task automatic latch_cfg();
        m_num   = int'(num_objs);
        m_gap   = int'(gap_size);
        m_speed = int'(speed);
        m_dir   = int'(direction);
        m_rowy  = int'(row_y);
        m_phase = 0;
        m_icnt  = 0;
        m_frames = 0;
        m_coll  = 0;
        m_hit   = 0;
        m_carry = 0;
    endtask

    task automatic model_step();
        int nc, nh, stepped, steps;
        if (!Reset) begin
            latch_cfg();
            for (int i = 0; i < NOBJ; i++) m_x[i] = 0;
            m_valid = 0;
            m_objy  = 0;
            m_known = 1'b1;
        end else if (!m_known) begin
        end else if (cfg_load) begin
            latch_cfg();
            m_valid = clamp_mask(m_num);
            m_objy  = m_rowy;
        end else begin
            nc = 0;
            nh = 0;
            stepped = 0;
            if (m_phase != 0) begin
                for (int i = NOBJ - 1; i >= 0; i--) begin
                    if (m_valid[i] && int'(frog_y) == m_objy &&
                        m_x[i] <= int'(frog_x) + OW && int'(frog_x) < m_x[i]) begin
                        nc = 1;
                        nh = i;
                    end
                end
            end
            if (m_phase == 0) begin
                m_x[m_icnt] = (m_icnt * (m_gap + OW)) % WRAP;
                m_valid = clamp_mask(m_num);
                m_objy  = m_rowy;
                m_icnt++;
                if (m_icnt == NOBJ) m_phase = run_en ? 1 : 2;
            end else if (m_phase == 1) begin
                m_frames++;
                if (m_speed != 0 && (m_frames % m_speed) == 0) begin
                    stepped = 1;
                    steps = (m_frames / m_speed) % WRAP;
                    for (int i = 0; i < NOBJ; i++) begin
                        if (m_dir != 0)
                            m_x[i] = ((i * (m_gap + OW)) % WRAP + steps) % WRAP;
                        else
                            m_x[i] = ((i * (m_gap + OW)) % WRAP - steps + WRAP) % WRAP;
                    end
                end
                if (!run_en) m_phase = 2;
            end else begin
                if (run_en) m_phase = 1;
            end
            m_carry = (CARRY_ON && stepped != 0 && m_coll != 0) ? 1 : 0;
            m_coll = nc;
            m_hit  = nh;
        end
    endtask

    initial forever begin
        @(posedge frame_clk);
        model_step();
    end

    initial forever begin
        @(posedge frame_clk);
        #1;
        if (m_known) begin
            check("busy", int'(busy), (m_phase == 0) ? 1 : 0);
            for (int i = 0; i < NOBJ; i++) check($sformatf("obj_x[%0d]", i), slot_x(i), m_x[i]);
            check("obj_y", int'(obj_y), m_objy);
            check("obj_valid", int'(obj_valid), m_valid);
            check("collision", int'(collision), m_coll);
            check("hit_idx", int'(hit_idx), m_hit);
            check("carry_step", int'(carry_step), m_carry);
            check("carry_dir", int'(carry_dir), CARRY_ON ? m_dir : 0);
        end
    end

    task automatic pulse_cfg();
        cfg_load = 1'b1;
        @(negedge frame_clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge frame_clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        int n;
        Reset = 1'b0; cfg_load = 1'b0; run_en = 1'b1;
        num_objs = 4'd4; gap_size = 8'd60; speed = 6'd0; direction = 1'b1;
        row_y = 11'd100; frog_x = 11'd0; frog_y = 11'd0;

        // reset and spawn positions
        @(negedge frame_clk);
        check("rst_busy", int'(busy), 1);
        check("rst_valid", int'(obj_valid), 0);
        Reset = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(negedge frame_clk);
            n++;
        end
        check("init_cycles", n, 8);
        check("spawn0", slot_x(0), 0);
        check("spawn3", slot_x(3), 300);
        check("spawn6", slot_x(6), 600);
        check("spawn7_wrap", slot_x(7), 20);
        check("valid_4", int'(obj_valid), 'h0F);
        check("obj_y_100", int'(obj_y), 100);

        // speed 0: frozen
        repeat (20) @(negedge frame_clk);
        check("frozen", slot_x(0), 0);

        // speed 3
        speed = 6'd3;
        pulse_cfg();
        wait_idle();
        repeat (2) @(negedge frame_clk);
        check("spd3_f2", slot_x(0), 0);
        @(negedge frame_clk);
        check("spd3_f3", slot_x(0), 1);
        repeat (3) @(negedge frame_clk);
        check("spd3_f6", slot_x(0), 2);
        run_en = 1'b0;
        repeat (5) @(negedge frame_clk);
        run_en = 1'b1;
        repeat (7) @(negedge frame_clk);

        // wrap right then left
        speed = 6'd1;
        pulse_cfg();
        wait_idle();
        repeat (679) @(negedge frame_clk);
        check("right_679", slot_x(0), 679);
        @(negedge frame_clk);
        check("right_wrap", slot_x(0), 0);
        direction = 1'b0;
        pulse_cfg();
        wait_idle();
        check("left_start", slot_x(0), 0);
        @(negedge frame_clk);
        check("left_wrap", slot_x(0), 679);
        @(negedge frame_clk);
        check("left_678", slot_x(0), 678);

        // collision on frozen row
        direction = 1'b1; speed = 6'd0;
        pulse_cfg();
        wait_idle();
        frog_y = 11'd100; frog_x = 11'd99;
        @(negedge frame_clk);
        check("hit_edge", int'(collision), 1);
        check("hit_edge_idx", int'(hit_idx), 1);
        frog_x = 11'd100;
        @(negedge frame_clk);
        check("miss_edge", int'(collision), 0);
        check("miss_edge_idx", int'(hit_idx), 0);
        frog_x = 11'd60;
        @(negedge frame_clk);
        check("hit_left", int'(collision), 1);
        frog_x = 11'd499;
        @(negedge frame_clk);
        check("invalid_slot5", int'(collision), 0);
        frog_x = 11'd700;
        @(negedge frame_clk);
        check("beyond_wrap", int'(collision), 0);
        frog_x = 11'd99; frog_y = 11'd101;
        @(negedge frame_clk);
        check("wrong_y", int'(collision), 0);

        // overlapping slots 1 and 5 at x=170: lowest index wins
        num_objs = 4'd8; gap_size = 8'd130; frog_y = 11'd100; frog_x = 11'd150;
        pulse_cfg();
        wait_idle();
        @(negedge frame_clk);
        check("multi_hit", int'(collision), 1);
        check("multi_idx", int'(hit_idx), 1);
        num_objs = 4'd0;
        pulse_cfg();
        wait_idle();
        @(negedge frame_clk);
        check("num0_nohit", int'(collision), 0);
        num_objs = 4'd15;
        pulse_cfg();
        wait_idle();
        check("num_clamp", int'(obj_valid), 'hFF);

        // cfg_load mid-run
        num_objs = 4'd4; gap_size = 8'd60; speed = 6'd1; frog_x = 11'd5;
        pulse_cfg();
        wait_idle();
        repeat (20) @(negedge frame_clk);
        num_objs = 4'd2;
        pulse_cfg();
        check("reload_valid", int'(obj_valid), 'h03);
        for (int k = 0; k < 8; k++) begin
            check("reload_busy", int'(busy), 1);
            check("reload_nocoll", int'(collision), 0);
            @(negedge frame_clk);
        end
        check("reload_done", int'(busy), 0);
        repeat (10) @(negedge frame_clk);
        Reset = 1'b0; cfg_load = 1'b1;
        @(negedge frame_clk);
        check("rstcfg_busy", int'(busy), 1);
        check("rstcfg_valid", int'(obj_valid), 0);
        check("rstcfg_y", int'(obj_y), 0);
        check("rstcfg_x3", slot_x(3), 0);
        check("rstcfg_coll", int'(collision), 0);
        Reset = 1'b1; cfg_load = 1'b0;

        // riding: frog at x=5 on slot 0 moving right 1 px/frame
        wait_idle();
        repeat (20) @(negedge frame_clk);
        check("ride_coll", int'(collision), 1);
        check("ride_carry", int'(carry_step), CARRY_ON ? 1 : 0);
        check("ride_dir", int'(carry_dir), CARRY_ON ? 1 : 0);
        frog_y = 11'd0;
        repeat (3) @(negedge frame_clk);
        check("off_carry", int'(carry_step), 0);
        repeat (2) @(negedge frame_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
